ex_muldiv: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID control decoder. Executes MULT, MULTU, MUL, DIV and DIVU using the decoder's multiply/divide select and unsigned-variant controls. Produces 64-bit {hi, lo} results for the HI/LO write path and the MUL register write, and stalls the pipeline while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/div_radix2.sv | 63 ++++++
 rtl/ex_muldiv.sv | 139 +++++++++++++
 tb/tb_ex_muldiv.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

  localparam int unsigned DIV_ITERS = 32;
  localparam logic [31:0] DIV0_LO   = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN   = 32'h80000000;

  // 33 bits so that the magnitude of INT_MIN is representable.
  function automatic logic [32:0] magnitude(input logic [31:0] v, input logic is_signed);
    logic [32:0] ext;
    ext = {is_signed & v[31], v};
    return ext[32] ? (~ext + 33'd1) : ext;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Iterative restoring radix-2 unsigned divider, one quotient bit per cycle.
module div_radix2
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [32:0] dividend,
  input  logic [32:0] divisor,
  output logic        busy,
  output logic        finish,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int unsigned CntW = $clog2(DIV_ITERS);

  logic [63:0]     acc_q, acc_d;
  logic [32:0]     dvsr_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic [32:0]     partial, trial;
  logic            fits;

  // acc_q holds {remainder, dividend/quotient}; partial is the remainder after the shift.
  always_comb begin
    partial = acc_q[63:31];
    trial   = partial - dvsr_q;
    fits    = (partial >= dvsr_q);
    acc_d   = fits ? {trial[31:0], acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      acc_q  <= {31'b0, dividend};
      dvsr_q <= divisor;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (finish) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Results are presented combinationally during the last iteration.
  assign busy      = busy_q;
  assign finish    = busy_q && (cnt_q == CntW'(DIV_ITERS - 1));
  assign quotient  = acc_d[31:0];
  assign remainder = acc_d[63:32];

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit producing {hi, lo} and a pipeline stall.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        op_mul,
  input  logic        op_div,
  input  logic        op_unsigned,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ack,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  state_e      state_q;
  logic [1:0]  mul_cnt_q;
  logic [31:0] a_q, b_q;
  logic        sign_a_q, sign_b_q, div0_q, ovf_q;

  logic        accept, div_start;
  logic [63:0] op_a_ext, op_b_ext, prod;
  logic        div_busy, div_finish;
  logic [31:0] div_quo, div_rem, quo_fix, rem_fix;

  assign accept    = (state_q == StIdle) && start && !flush && (op_mul ^ op_div);
  assign div_start = accept && op_div;

  // Low 64 bits of the product are the same for signed and unsigned once sign-extended.
  assign op_a_ext = {{32{sign_a_q}}, a_q};
  assign op_b_ext = {{32{sign_b_q}}, b_q};
  assign prod     = op_a_ext * op_b_ext;

  assign quo_fix = (sign_a_q ^ sign_b_q) ? (~div_quo + 32'd1) : div_quo;
  assign rem_fix = sign_a_q ? (~div_rem + 32'd1) : div_rem;

  div_radix2 u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .abort     (flush),
    .dividend  (magnitude(src_a, !op_unsigned)),
    .divisor   (magnitude(src_b, !op_unsigned)),
    .busy      (div_busy),
    .finish    (div_finish),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      mul_cnt_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      hi_res    <= '0;
      lo_res    <= '0;
      done      <= 1'b0;
    end else if (flush) begin
      state_q   <= StIdle;
      mul_cnt_q <= '0;
      done      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            a_q       <= src_a;
            b_q       <= src_b;
            sign_a_q  <= !op_unsigned && src_a[31];
            sign_b_q  <= !op_unsigned && src_b[31];
            div0_q    <= (src_b == 32'd0);
            ovf_q     <= !op_unsigned && (src_a == INT_MIN) && (src_b == 32'hFFFFFFFF);
            mul_cnt_q <= '0;
            state_q   <= op_mul ? StMul : StDiv;
          end
        end
        StMul: begin
          if (mul_cnt_q == 2'(MUL_CYCLES - 1)) begin
            hi_res  <= prod[63:32];
            lo_res  <= prod[31:0];
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            mul_cnt_q <= mul_cnt_q + 2'd1;
          end
        end
        StDiv: begin
          if (div_finish) begin
            if (div0_q) begin
              hi_res <= a_q;
              lo_res <= DIV0_LO;
            end else if (ovf_q) begin
              hi_res <= '0;
              lo_res <= INT_MIN;
            end else begin
              hi_res <= rem_fix;
              lo_res <= quo_fix;
            end
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          // A start seen together with ack is the instruction being retired.
          if (ack) begin
            done    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall = start & ~done;

  always_ff @(posedge clk) begin
    if (resetn && (state_q == StIdle) && start && !flush) begin
      assert (op_mul ^ op_div)
      else $error("ex_muldiv: start with invalid mul/div select");
    end
    if (resetn && (state_q == StDiv)) begin
      assert (div_busy)
      else $error("ex_muldiv: divider idle while in DIV state");
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed ops with hand-computed results and latencies.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        op_mul = 1'b0;
  logic        op_div = 1'b0;
  logic        op_unsigned = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        ack = 1'b0;
  logic        flush = 1'b0;
  logic        stall, done;
  logic [31:0] hi_res, lo_res;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  always #5 clk = ~clk;

  ex_muldiv #(.MUL_CYCLES(2)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .op_mul      (op_mul),
    .op_div      (op_div),
    .op_unsigned (op_unsigned),
    .src_a       (src_a),
    .src_b       (src_b),
    .ack         (ack),
    .flush       (flush),
    .stall       (stall),
    .done        (done),
    .hi_res      (hi_res),
    .lo_res      (lo_res)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: results are consumed on the done & ack cycle.
  always @(negedge clk) begin
    if (resetn && done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: done=1 with no pending op (hi=0x%08h lo=0x%08h)",
                 hi_res, lo_res);
      end else if (ack) begin
        mon_e = exp_q.pop_front();
        check("result_hi", hi_res, mon_e[63:32]);
        check("result_lo", lo_res, mon_e[31:0]);
      end
    end
  end

  task automatic do_op(input logic mul, input logic uns, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int lat, input bit hold);
    int cyc;
    bit stall_bad;
    exp_q.push_back({eh, el});
    step();
    start = 1'b1; op_mul = mul; op_div = ~mul; op_unsigned = uns;
    src_a = a; src_b = b; ack = ~hold;
    #1;
    stall_bad = (stall !== 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
      if (done !== 1'b1 && stall !== 1'b1) stall_bad = 1'b1;
    end
    check("latency", 32'(cyc), 32'(lat));
    check("stall_before_done", {31'b0, stall_bad}, 32'd0);
    check("stall_at_done", {31'b0, stall}, 32'd0);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        step();
        check("hold_done", {31'b0, done}, 32'd1);
        check("hold_hi", hi_res, eh);
        check("hold_lo", lo_res, el);
      end
      ack = 1'b1;
    end
    step();
    start = 1'b0;
    check("done_after_ack", {31'b0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_hi", hi_res, 32'd0);
    check("reset_lo", lo_res, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    resetn = 1'b1;

    //    mul   uns   src_a          src_b          hi             lo             lat hold
    do_op(1'b1, 1'b0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB,  3, 1'b0);
    do_op(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001,  3, 1'b0);
    do_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000,  3, 1'b0);
    do_op(1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
    do_op(1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b0);
    do_op(1'b0, 1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 1'b0);
    do_op(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33, 1'b0);
    do_op(1'b0, 1'b1, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33, 1'b0);
    do_op(1'b0, 1'b0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 33, 1'b0);
    do_op(1'b1, 1'b0, 32'd6,        32'd7,        32'd0,        32'd42,        3, 1'b1);

    // Flush a DIVU 100/7 in cycle 10; the previous 6*7 result must survive.
    step();
    start = 1'b1; op_mul = 1'b0; op_div = 1'b1; op_unsigned = 1'b1;
    src_a = 32'd100; src_b = 32'd7; ack = 1'b1;
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0; start = 1'b0;
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_hi", hi_res, 32'd0);
    check("flush_lo", lo_res, 32'd42);
    repeat (40) step();
    check("flush_no_done", {31'b0, done}, 32'd0);
    do_op(1'b1, 1'b0, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB,  3, 1'b0);

    // Reset in cycle 20 of a DIV.
    step();
    start = 1'b1; op_mul = 1'b0; op_div = 1'b1; op_unsigned = 1'b0;
    src_a = 32'hFFFFFFF9; src_b = 32'd2; ack = 1'b1;
    repeat (20) step();
    resetn = 1'b0;
    step();
    check("midreset_done", {31'b0, done}, 32'd0);
    check("midreset_hi", hi_res, 32'd0);
    check("midreset_lo", lo_res, 32'd0);
    check("midreset_stall", {31'b0, stall}, {31'b0, start});
    resetn = 1'b1; start = 1'b0;
    do_op(1'b1, 1'b1, 32'h00010000, 32'h00010000, 32'd1,        32'd0,         3, 1'b0);

    repeat (3) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
